// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment width, the
// abcdefg patterns for each digit (decimal and hex) and the "bad value" code.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Bit order is a(6) b(5) c(4) d(3) e(2) f(1) g(0).
    localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;

    localparam logic [SEG_W-1:0] SEG_HA = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HB = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_HC = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_HD = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_HE = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HF = 7'h47;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [3:0]       BAD_VAL   = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational abcdefg -> {ok, value} decoder. Hex letters A..F decode only
// when SEG7_HEX_EN is defined; otherwise they are reported as bad (F, ok=0).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_ok,
    output logic [3:0]       o_val
);

    always_comb begin
        o_ok  = 1'b1;
        o_val = BAD_VAL;
        case (i_seg)
            SEG_0:   o_val = 4'h0;
            SEG_1:   o_val = 4'h1;
            SEG_2:   o_val = 4'h2;
            SEG_3:   o_val = 4'h3;
            SEG_4:   o_val = 4'h4;
            SEG_5:   o_val = 4'h5;
            SEG_6:   o_val = 4'h6;
            SEG_7:   o_val = 4'h7;
            SEG_8:   o_val = 4'h8;
            SEG_9:   o_val = 4'h9;
`ifdef SEG7_HEX_EN
            SEG_HA:  o_val = 4'hA;
            SEG_HB:  o_val = 4'hB;
            SEG_HC:  o_val = 4'hC;
            SEG_HD:  o_val = 4'hD;
            SEG_HE:  o_val = 4'hE;
            SEG_HF:  o_val = 4'hF;
`endif
            default: begin
                o_ok  = 1'b0;
                o_val = BAD_VAL;
            end
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Recovers digit values from a multiplexed 7-segment bus and emits whole frames
// on a valid/ready stream. Optional hex-letter decode via SEG7_HEX_EN.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_data,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // Input sample (s_t) and the sample before it (s_t-1).
    logic [SEG_W-1:0]      r_seg;
    logic [SEG_W-1:0]      r_seg_prev;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [NUM_DIGITS-1:0] r_sel_prev;

    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_same;
    logic                  w_one_hot;
    logic                  w_capture;

    logic [SEG_W-1:0]      w_seg_pos;
    logic                  w_dec_ok;
    logic [3:0]            w_dec_val;

    logic [3:0]            r_slot_val [NUM_DIGITS];
    logic                  r_slot_err [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_mask;
    logic [NUM_DIGITS-1:0] w_wr_en;
    logic [NUM_DIGITS-1:0] w_mask_set;
    logic [4*NUM_DIGITS-1:0] w_frame_data;
    logic [NUM_DIGITS-1:0] w_frame_err;
    logic                  w_frame_done;
    logic                  w_load;
    logic                  w_accept;

    logic                    r_out_valid;
    logic [4*NUM_DIGITS-1:0] r_out_data;
    logic [NUM_DIGITS-1:0]   r_out_err;
    logic                    r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg      <= SEG_BLANK;
            r_seg_prev <= SEG_BLANK;
            r_sel      <= '0;
            r_sel_prev <= '0;
        end else begin
            r_seg      <= seg_in;
            r_seg_prev <= r_seg;
            r_sel      <= dig_sel;
            r_sel_prev <= r_sel;
        end
    end

    assign w_seg_pos = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
    assign w_same    = (r_seg == r_seg_prev) && (r_sel == r_sel_prev);

    // Counter saturates at CNT_MAX so a long dwell captures exactly once; a
    // fresh sample restarts at 1 so STABLE_CYCLES==1 still captures.
    always_comb begin
        w_one_hot  = ($countones(r_sel) == 1);
        w_cnt_next = '0;
        w_capture  = 1'b0;
        if (w_one_hot) begin
            if (!w_same) begin
                w_cnt_next = CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_next = r_cnt + 1'b1;
            end else begin
                w_cnt_next = r_cnt;
            end
            w_capture = (w_cnt_next == CNT_MAX) && (!w_same || (r_cnt != CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    seg7_pattern_decode u_decode (
        .i_seg (w_seg_pos),
        .o_ok  (w_dec_ok),
        .o_val (w_dec_val)
    );

    assign w_wr_en = w_capture ? r_sel : '0;

    // The completing digit is merged in combinationally so the frame can load
    // on the same edge it is captured.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot_val[gi] <= 4'h0;
                r_slot_err[gi] <= 1'b0;
            end else if (w_wr_en[gi]) begin
                r_slot_val[gi] <= w_dec_val;
                r_slot_err[gi] <= !w_dec_ok;
            end
        end

        assign w_frame_data[4*gi +: 4] = w_wr_en[gi] ? w_dec_val : r_slot_val[gi];
        assign w_frame_err[gi]         = w_wr_en[gi] ? !w_dec_ok : r_slot_err[gi];
    end

    assign w_mask_set   = r_mask | w_wr_en;
    assign w_frame_done = w_capture && (&w_mask_set);
    assign w_accept     = r_out_valid && out_ready;
    assign w_load       = w_frame_done && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_mask <= w_frame_done ? '0 : w_mask_set;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_frame_data;
                r_out_err   <= w_frame_err;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            // Held frame is stalled: the new one is dropped, not queued.
            if (w_frame_done && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: directed scenarios plus random dwell
// sequences, compared every cycle against a sample-history reference model.
module tb_seg7_readback;

    localparam int N = 4;
    localparam int S = 4;
`ifdef SEG7_HEX_EN
    localparam int NDEC = 16;
`else
    localparam int NDEC = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_in = 7'h00;
    logic [N-1:0]  dig_sel = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [4*N-1:0] out_data;
    logic [N-1:0]  out_err;
    logic          overrun;

    always #5 clk = ~clk;

    seg7_readback #(
        .NUM_DIGITS     (N),
        .STABLE_CYCLES  (S),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Digit v is shown as pat[v].
    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] v, output bit e);
        v = 4'hF;
        e = 1'b1;
        for (int i = 0; i < NDEC; i++) begin
            if (s == pat[i]) begin
                v = 4'(i);
                e = 1'b0;
            end
        end
    endtask

    // Reference model: every registered sample is kept in a short history; a
    // digit is captured when the most recent run of identical samples is
    // exactly S long and names one slot.
    logic [10:0]    hist [$];
    logic [3:0]     m_val [N];
    bit             m_err [N];
    bit [N-1:0]     m_mask;
    bit             exp_valid;
    logic [4*N-1:0] exp_data;
    logic [N-1:0]   exp_err;
    bit             exp_ovr;
    int             acc_frames = 0;
    logic [4*N-1:0] acc_last   = '0;
    logic [N-1:0]   acc_last_err = '0;

    task automatic model_step();
        logic [10:0] last;
        int          run;
        int          idx;
        logic [3:0]  v;
        bit          e;
        bit          accepted;
        bit          loaded;
        if (rst) begin
            hist.delete();
            hist.push_back(11'h0);
            hist.push_back(11'h0);
            m_mask    = '0;
            for (int i = 0; i < N; i++) begin
                m_val[i] = 4'h0;
                m_err[i] = 1'b0;
            end
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_err   = '0;
            exp_ovr   = 1'b0;
            return;
        end
        last = hist[hist.size()-1];
        run  = 0;
        for (int i = hist.size()-1; i >= 0 && hist[i] == last; i--) run++;
        accepted = exp_valid && out_ready;
        loaded   = 1'b0;
        if (accepted) begin
            acc_frames++;
            acc_last     = exp_data;
            acc_last_err = exp_err;
            $display("frame accepted: data=%h err=%b", exp_data, exp_err);
        end
        if ($countones(last[N-1:0]) == 1 && run == S) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (last[i]) idx = i;
            ref_decode(last[10:4], v, e);
            m_val[idx]  = v;
            m_err[idx]  = e;
            m_mask[idx] = 1'b1;
            if (&m_mask) begin
                m_mask = '0;
                if (!exp_valid || out_ready) begin
                    loaded    = 1'b1;
                    exp_valid = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        exp_data[4*i +: 4] = m_val[i];
                        exp_err[i]         = m_err[i];
                    end
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
        if (accepted && !loaded) exp_valid = 1'b0;
        hist.push_back({seg_in, dig_sel});
        while (hist.size() > S + 2) void'(hist.pop_front());
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",   32'(out_valid), 32'(exp_valid));
            check("data",    32'(out_data),  32'(exp_data));
            check("err",     32'(out_err),   32'(exp_err));
            check("overrun", 32'(overrun),   32'(exp_ovr));
        end
    end

    task automatic tick(input logic [6:0] s, input logic [N-1:0] sel, input logic rdy);
        seg_in    = s;
        dig_sel   = sel;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic dwell(input logic [6:0] s, input logic [N-1:0] sel, input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(s, sel, rdy);
    endtask

    // pats holds slot 0 in the low 7 bits.
    task automatic send_frame(input logic [27:0] pats, input int n, input logic rdy);
        for (int d = 0; d < N; d++) dwell(pats[7*d +: 7], N'(1) << d, n, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(7'h00, '0, 1'b0);
        tick(7'h00, '0, 1'b0);
        rst = 1'b0;
    endtask

    int base;
    int pct;

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_valid",   32'(out_valid), 32'h0);
        check("reset_data",    32'(out_data),  32'h0);
        check("reset_overrun", 32'(overrun),   32'h0);

        // Plain 0..3 frame, consumer always ready.
        base = acc_frames;
        send_frame({7'h79, 7'h6D, 7'h30, 7'h7E}, 6, 1'b1);
        dwell(7'h00, '0, 3, 1'b1);
        check("t1_frames", 32'(acc_frames - base), 32'd1);
        check("t1_data",   32'(acc_last), 32'h3210);
        check("t1_err",    32'(acc_last_err), 32'h0);

        // Letter A in slot 2; also pins the S+1 latency of the last digit.
        dwell(7'h7E, 4'b0001, 6, 1'b0);
        dwell(7'h30, 4'b0010, 6, 1'b0);
        dwell(7'h77, 4'b0100, 6, 1'b0);
        dwell(7'h79, 4'b1000, 4, 1'b0);
        check("t2_latency_low", 32'(out_valid), 32'h0);
        dwell(7'h79, 4'b1000, 1, 1'b0);
        check("t2_latency_high", 32'(out_valid), 32'h1);
        dwell(7'h79, 4'b1000, 2, 1'b0);
`ifdef SEG7_HEX_EN
        check("t2_data", 32'(out_data), 32'h3A10);
        check("t2_err",  32'(out_err),  32'h0);
`else
        check("t2_data", 32'(out_data), 32'h3F10);
        check("t2_err",  32'(out_err),  32'h4);
`endif
        tick(7'h00, '0, 1'b1);
        check("t2_accepted", 32'(out_valid), 32'h0);

        // Slot 1 too short on the first visit.
        dwell(7'h7E, 4'b0001, 6, 1'b0);
        dwell(7'h30, 4'b0010, 3, 1'b0);
        dwell(7'h6D, 4'b0100, 6, 1'b0);
        dwell(7'h79, 4'b1000, 6, 1'b0);
        check("t3_no_frame", 32'(out_valid), 32'h0);
        dwell(7'h30, 4'b0010, 5, 1'b0);
        check("t3_frame_valid", 32'(out_valid), 32'h1);
        check("t3_frame_data",  32'(out_data),  32'h3210);
        tick(7'h00, '0, 1'b1);

        // Multi-hot select never captures.
        dwell(7'h7E, 4'b0011, 10, 1'b0);
        check("t4_no_frame", 32'(out_valid), 32'h0);
        dwell(7'h00, '0, 2, 1'b0);

        // Two frames while stalled: first is held, second dropped.
        send_frame({7'h33, 7'h79, 7'h6D, 7'h30}, 6, 1'b0);
        send_frame({7'h7F, 7'h70, 7'h5F, 7'h5B}, 6, 1'b0);
        check("t5_valid",   32'(out_valid), 32'h1);
        check("t5_held",    32'(out_data),  32'h4321);
        check("t5_err",     32'(out_err),   32'h0);
        check("t5_overrun", 32'(overrun),   32'h1);
        tick(7'h00, '0, 1'b1);
        check("t5_accepted",      32'(out_valid), 32'h0);
        check("t5_overrun_stays", 32'(overrun),   32'h1);

        // Reset in the middle of a frame.
        do_reset();
        dwell(7'h7B, 4'b0001, 6, 1'b0);
        dwell(7'h7F, 4'b0010, 6, 1'b0);
        dwell(7'h70, 4'b0100, 6, 1'b0);
        do_reset();
        check("t6_valid",   32'(out_valid), 32'h0);
        check("t6_data",    32'(out_data),  32'h0);
        check("t6_err",     32'(out_err),   32'h0);
        check("t6_overrun", 32'(overrun),   32'h0);
        base = acc_frames;
        send_frame({7'h5F, 7'h70, 7'h7F, 7'h7B}, 6, 1'b1);
        dwell(7'h00, '0, 3, 1'b1);
        check("t6_frames", 32'(acc_frames - base), 32'd1);
        check("t6_data",   32'(acc_last), 32'h6789);

        // Random dwell sequences with a random consumer.
        for (int ph = 0; ph < 300; ph++) begin
            logic [6:0]   s;
            logic [N-1:0] sel;
            int           len;
            if ($urandom_range(0, 3) != 0) s = pat[$urandom_range(0, 15)];
            else                           s = 7'($urandom);
            if ($urandom_range(0, 4) != 0) sel = N'(1) << $urandom_range(0, N-1);
            else                           sel = N'($urandom);
            len = $urandom_range(1, 7);
            pct = $urandom_range(10, 100);
            for (int k = 0; k < len; k++) tick(s, sel, ($urandom_range(0, 99) < pct));
        end
        dwell(7'h00, '0, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
